// File: rtl/alu_share_if.sv
// Bundle between the two ALU requesters, the shared ALU and the response path.
// The arbiter takes the slave side; the pipeline/ALU environment takes the master side.
interface alu_share_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [OPW-1:0]   req0_op;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [OPW-1:0]   req1_op;
    logic             req1_ready;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_out;
    logic [1:0]       rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_illegal;
    logic [1:0]       rsp_ready;
    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  alu_out, rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_op,
        output rsp_valid, rsp_data, rsp_illegal, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output alu_out, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_data, rsp_illegal, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between execute (req0)
// and the address/branch unit (req1); registered operands, held response.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input logic        clk,
    input logic        rst,
    alu_share_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_op_q, alu_op_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_illegal_q, rsp_illegal_d;
    logic             last_grant_q, last_grant_d;
    logic             gnt;
    logic             ready0, ready1;

    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_illegal_d = rsp_illegal_q;
        last_grant_d  = last_grant_q;
        ready0        = 1'b0;
        ready1        = 1'b0;
        // On a tie the requester not served last time wins
        gnt = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q
                                                 : bus.req1_valid;
        unique case (state_q)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    ready0       = ~gnt;
                    ready1       = gnt;
                    alu_a_d      = gnt ? bus.req1_a  : bus.req0_a;
                    alu_b_d      = gnt ? bus.req1_b  : bus.req0_b;
                    alu_op_d     = gnt ? bus.req1_op : bus.req0_op;
                    last_grant_d = gnt;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d    = bus.alu_out;
                rsp_illegal_d = alu_op_q > OPW'(3);
                rsp_valid_d   = last_grant_q ? 2'b10 : 2'b01;
                state_d       = RESP;
            end
            RESP: begin
                if (bus.rsp_ready[last_grant_q]) begin
                    rsp_valid_d = 2'b00;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            rsp_valid_q   <= 2'b00;
            rsp_data_q    <= '0;
            rsp_illegal_q <= 1'b0;
            last_grant_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_illegal_q <= rsp_illegal_d;
            last_grant_q  <= last_grant_d;
        end
    end

    assign bus.req0_ready  = ready0 && !rst;
    assign bus.req1_ready  = ready1 && !rst;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_illegal = rsp_illegal_q;
    assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed cases then random rounds
// checked against a request-level model of arbitration and results.
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    alu_share_if #(.WIDTH(32), .OPW(3)) bus ();

    alu_share_arbiter #(.WIDTH(32), .OPW(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            default: return 32'd0;
        endcase
    endfunction

    always_comb bus.alu_out = ref_alu(bus.alu_op, bus.alu_a, bus.alu_b);

    // Model state: pending request per requester and last grant
    bit          pv [2];
    logic [31:0] pa [2];
    logic [31:0] pb [2];
    logic [2:0]  pop[2];
    int          m_last;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        bus.req0_valid = pv[0];
        bus.req0_a     = pa[0];
        bus.req0_b     = pb[0];
        bus.req0_op    = pop[0];
        bus.req1_valid = pv[1];
        bus.req1_a     = pa[1];
        bus.req1_b     = pb[1];
        bus.req1_op    = pop[1];
    endtask

    task automatic set_req(input int i, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        pv[i]  = 1'b1;
        pop[i] = op;
        pa[i]  = a;
        pb[i]  = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.rsp_ready  = 2'b00;
        @(negedge clk);
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_ready1", bus.req1_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_b", bus.alu_b, 0);
        chk("rst_alu_op", bus.alu_op, 0);
        chk("rst_rspv", bus.rsp_valid, 0);
        chk("rst_rspd", bus.rsp_data, 0);
        chk("rst_ill", bus.rsp_illegal, 0);
        chk("rst_busy", bus.busy, 0);
        @(posedge clk); #1;
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        drive();
        rst = 1'b0;
        m_last = 1;
    endtask

    // One arbitration round, starting just after a rising edge in IDLE.
    // nstall < 0 picks a random stall length for the response.
    task automatic round(input bit rnd, input int nstall);
        int          g, n;
        logic [31:0] exp_d, ea, eb;
        logic [2:0]  eop;
        logic [1:0]  r;
        if (rnd) begin
            for (int i = 0; i < 2; i++) begin
                if (!pv[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 3'($urandom_range(0, 7)), $urandom, $urandom);
            end
        end
        drive();
        @(negedge clk);
        chk("idle_busy", bus.busy, 0);
        chk("idle_rspv", bus.rsp_valid, 0);
        if (!pv[0] && !pv[1]) begin
            chk("none_ready0", bus.req0_ready, 0);
            chk("none_ready1", bus.req1_ready, 0);
            @(posedge clk); #1;
            return;
        end
        if (pv[0] && pv[1]) g = (m_last == 0) ? 1 : 0;
        else g = pv[1] ? 1 : 0;
        chk("grant_ready0", bus.req0_ready, (g == 0));
        chk("grant_ready1", bus.req1_ready, (g == 1));
        ea = pa[g];
        eb = pb[g];
        eop = pop[g];
        exp_d = ref_alu(eop, ea, eb);
        @(posedge clk); #1;
        m_last = g;
        pv[g] = 1'b0;
        drive();
        @(negedge clk);
        chk("exec_busy", bus.busy, 1);
        chk("exec_alu_a", bus.alu_a, ea);
        chk("exec_alu_b", bus.alu_b, eb);
        chk("exec_alu_op", bus.alu_op, eop);
        chk("exec_ready0", bus.req0_ready, 0);
        chk("exec_ready1", bus.req1_ready, 0);
        chk("exec_rspv", bus.rsp_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rsp_valid", bus.rsp_valid, 64'(1) << g);
        chk("rsp_data", bus.rsp_data, exp_d);
        chk("rsp_illegal", bus.rsp_illegal, (eop > 3));
        n = (nstall < 0) ? $urandom_range(0, 3) : nstall;
        for (int k = 0; k < n; k++) begin
            r = 2'($urandom_range(0, 3));
            r[g] = 1'b0;
            bus.rsp_ready = r;
            @(negedge clk);
            chk("hold_valid", bus.rsp_valid, 64'(1) << g);
            chk("hold_data", bus.rsp_data, exp_d);
            chk("hold_ill", bus.rsp_illegal, (eop > 3));
            chk("hold_ready0", bus.req0_ready, 0);
            chk("hold_ready1", bus.req1_ready, 0);
            chk("hold_alu_a", bus.alu_a, ea);
        end
        r = 2'($urandom_range(0, 3));
        r[g] = 1'b1;
        bus.rsp_ready = r;
        @(posedge clk); #1;
        bus.rsp_ready = 2'b00;
    endtask

    initial begin
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pa[i] = '0;
            pb[i] = '0;
            pop[i] = '0;
        end
        m_last = 1;
        @(posedge clk); #1;
        do_reset();

        set_req(0, 3'd0, 32'd5, 32'd3);
        round(0, 0);

        do_reset();
        set_req(0, 3'd1, 32'd10, 32'd3);
        set_req(1, 3'd2, 32'hF0, 32'h3C);
        round(0, 0);
        round(0, 0);
        set_req(0, 3'd3, 32'h11, 32'h22);
        set_req(1, 3'd0, 32'h1, 32'h2);
        round(0, 4);
        round(0, 2);

        set_req(1, 3'd5, 32'd7, 32'd9);
        round(0, 0);

        // Reset while req1 is in EXEC: its response must never appear
        set_req(1, 3'd0, 32'd40, 32'd2);
        drive();
        @(negedge clk);
        chk("r5_ready1", bus.req1_ready, 1);
        @(posedge clk); #1;
        pv[1] = 1'b0;
        drive();
        rst = 1'b1;
        @(negedge clk);
        chk("r5_exec_busy", bus.busy, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        m_last = 1;
        @(negedge clk);
        chk("r5_rspv", bus.rsp_valid, 0);
        chk("r5_alu_a", bus.alu_a, 0);
        chk("r5_rspd", bus.rsp_data, 0);
        chk("r5_busy", bus.busy, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("r5_rspv2", bus.rsp_valid, 0);
        @(posedge clk); #1;
        set_req(0, 3'd2, 32'hFF, 32'h0F);
        set_req(1, 3'd3, 32'h1, 32'h2);
        round(0, 0);
        round(0, 0);

        set_req(0, 3'd1, 32'd0, 32'd1);
        round(0, 0);
        set_req(1, 3'd0, 32'hFFFF_FFFF, 32'd1);
        round(0, 0);
        set_req(0, 3'd3, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
        round(0, 0);

        for (int t = 0; t < 300; t++) round(1, -1);
        while (pv[0] || pv[1]) round(0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
